// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and FETCH/EXEC phase sequencer.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   stall               repeat the current EXEC (multi-cycle load)
//   instruction_word    instruction currently in EXEC
//   rs_data             rs read value for the instruction in EXEC
//   jump_addr_selection registered branch decision: 00 none, 01 reg, 10 page, 11 rel
//   pc                  fetch/exec address
//   state               0 = FETCH, 1 = EXEC
//   link_addr           pc + 8
//   active              high until control transfers to HALT_ADDR
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] instruction_word,
  input  logic [31:0] rs_data,
  input  logic [1:0]  jump_addr_selection,
  output logic [31:0] pc,
  output logic        state,
  output logic [31:0] link_addr,
  output logic        active
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} st_e;

  // Candidate targets captured from the instruction in EXEC; consumed one
  // EXEC later, once the delay-slot instruction has completed.
  typedef struct packed {
    logic [31:0] reg_t;
    logic [31:0] page_t;
    logic [31:0] rel_t;
  } tgt_t;

  st_e         st, st_nxt;
  tgt_t        tgt;
  logic        slot_pending;
  logic [31:0] pc_plus4, rel_off, sel_tgt, pc_nxt;
  logic [15:0] imm;
  logic        upd, taken, halt_hit;
  logic        unused_opcode;

  assign unused_opcode = ^instruction_word[31:26];

  assign pc_plus4 = pc + 32'd4;
  assign imm      = instruction_word[15:0];
  assign rel_off  = {{14{imm[15]}}, imm, 2'b00};
  assign upd      = (st == S_EXEC) && !stall;

  // Branch control is not reset, so its selection is only trusted once a
  // full EXEC has completed since reset.
  assign taken    = slot_pending && (jump_addr_selection != 2'b00);

  always_comb begin
    sel_tgt = pc_plus4;
    case (jump_addr_selection)
      2'b01:   sel_tgt = tgt.reg_t;
      2'b10:   sel_tgt = tgt.page_t;
      2'b11:   sel_tgt = tgt.rel_t;
      default: sel_tgt = pc_plus4;
    endcase
  end

  assign pc_nxt   = taken ? sel_tgt : pc_plus4;
  // Only a taken transfer halts; sequential wrap to 0 keeps running.
  assign halt_hit = taken && (sel_tgt == HALT_ADDR);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= S_FETCH;
    else          st <= st_nxt;
  end

  // FSM: next state
  always_comb begin
    st_nxt = st;
    case (st)
      S_FETCH: st_nxt = S_EXEC;
      S_EXEC:  if (!stall) st_nxt = halt_hit ? S_HALT : S_FETCH;
      S_HALT:  st_nxt = S_HALT;
      default: st_nxt = S_FETCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    state     = (st == S_EXEC);
    active    = (st != S_HALT);
    link_addr = pc + 32'd8;
  end

  // Datapath: capture and PC update share the EXEC->FETCH edge; the update
  // reads the old targets so a branch in a delay slot can't clobber them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_VECTOR;
      tgt          <= '0;
      slot_pending <= 1'b0;
    end else if (upd) begin
      tgt.reg_t    <= rs_data;
      tgt.page_t   <= {pc_plus4[31:28], instruction_word[25:0], 2'b00};
      tgt.rel_t    <= pc_plus4 + rel_off;
      slot_pending <= 1'b1;
      pc           <= halt_hit ? HALT_ADDR : pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instruction_word = '0;
  logic [31:0] rs_data = '0;
  logic [1:0]  jump_addr_selection = 2'b00;
  logic [31:0] pc, link_addr;
  logic        state, active;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] RV  = 32'hBFC00000;

  pc_sequencer dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .instruction_word(instruction_word), .rs_data(rs_data),
    .jump_addr_selection(jump_addr_selection),
    .pc(pc), .state(state), .link_addr(link_addr), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    jump_addr_selection = 2'b00;
    instruction_word = NOP;
    rs_data = '0;
    tick();
    reset_n = 1'b1;
  endtask

  // One FETCH+EXEC with the given instruction/rs value; sel is the branch
  // decision for the previous instruction, visible during this one.
  task automatic exec_one(input logic [31:0] iw, input logic [31:0] rs, input logic [1:0] sel);
    instruction_word = iw;
    rs_data = rs;
    jump_addr_selection = sel;
    tick();
    tick();
    jump_addr_selection = 2'b00;
  endtask

  initial begin
    // Reset state and sequential stepping
    do_reset();
    chk("rst_pc", pc, RV);
    chk("rst_state", {31'b0, state}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd1);
    chk("rst_link", link_addr, 32'hBFC00008);
    begin
      logic [31:0] exp_pc [6] = '{RV, RV+4, RV+4, RV+8, RV+8, RV+12};
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("seq_pc%0d", i), pc, exp_pc[i]);
        chk($sformatf("seq_st%0d", i), {31'b0, state}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
    end

    // BEQ +3 at BFC00000
    do_reset();
    exec_one(32'h10000003, 0, 2'b00);
    chk("beq_slot_pc", pc, 32'hBFC00004);
    exec_one(NOP, 0, 2'b11);
    chk("beq_tgt", pc, 32'hBFC00010);

    // Negative offset at BFC00008
    do_reset();
    exec_one(NOP, 0, 2'b00);
    exec_one(NOP, 0, 2'b00);
    exec_one(32'h1000FFFE, 0, 2'b00);
    exec_one(NOP, 0, 2'b11);
    chk("bneg_tgt", pc, 32'hBFC00004);

    // Page jump J 0x100 from BFC00000
    do_reset();
    exec_one(32'h08000100, 0, 2'b00);
    exec_one(NOP, 0, 2'b10);
    chk("j_tgt", pc, 32'hB0000400);

    // Branch in delay slot: old target wins, then the slot branch's target
    do_reset();
    exec_one(32'h10000003, 0, 2'b00);
    exec_one(32'h10000010, 0, 2'b11);
    chk("bb_first", pc, 32'hBFC00010);
    exec_one(NOP, 0, 2'b11);
    chk("bb_second", pc, 32'hBFC00048);

    // Unaligned register target passes through
    do_reset();
    exec_one(32'h00000008, 32'h12345677, 2'b00);
    exec_one(NOP, 0, 2'b01);
    chk("jr_unaligned", pc, 32'h12345677);

    // Sequential wrap to 0 does not halt
    do_reset();
    exec_one(32'h00000008, 32'hFFFFFFFC, 2'b00);
    exec_one(NOP, 0, 2'b01);
    chk("wrap_pre", pc, 32'hFFFFFFFC);
    exec_one(NOP, 0, 2'b00);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_active", {31'b0, active}, 32'd1);
    tick();
    chk("wrap_state", {31'b0, state}, 32'd1);

    // JR to 0 at BFC0000C halts
    do_reset();
    exec_one(NOP, 0, 2'b00);
    exec_one(NOP, 0, 2'b00);
    exec_one(NOP, 0, 2'b00);
    chk("jr0_pre", pc, 32'hBFC0000C);
    exec_one(32'h00000008, 32'h0, 2'b00);
    chk("jr0_slot", pc, 32'hBFC00010);
    chk("jr0_slot_act", {31'b0, active}, 32'd1);
    exec_one(NOP, 0, 2'b01);
    chk("halt_pc", pc, 32'h0);
    chk("halt_active", {31'b0, active}, 32'd0);
    chk("halt_state", {31'b0, state}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      stall = i[0];
      jump_addr_selection = 2'b11;
      tick();
      chk($sformatf("halt_hold_pc%0d", i), pc, 32'h0);
      chk($sformatf("halt_hold_st%0d", i), {31'b0, state}, 32'd0);
    end
    chk("halt_hold_act", {31'b0, active}, 32'd0);

    // Stall in delay slot EXEC
    do_reset();
    exec_one(32'h10000003, 0, 2'b00);
    jump_addr_selection = 2'b11;
    tick();
    chk("stl_enter", {31'b0, state}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stl_st%0d", i), {31'b0, state}, 32'd1);
      chk($sformatf("stl_pc%0d", i), pc, 32'hBFC00004);
    end
    stall = 1'b0;
    tick();
    chk("stl_tgt", pc, 32'hBFC00010);
    chk("stl_fetch", {31'b0, state}, 32'd0);

    // Selection right after reset is ignored
    do_reset();
    exec_one(NOP, 0, 2'b11);
    chk("ign_sel", pc, 32'hBFC00004);

    // Async reset mid-EXEC discards the pending target
    do_reset();
    exec_one(32'h10000003, 0, 2'b00);
    jump_addr_selection = 2'b11;
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_pc", pc, RV);
    chk("arst_state", {31'b0, state}, 32'd0);
    #1;
    reset_n = 1'b1;
    exec_one(NOP, 0, 2'b11);
    chk("arst_discard", pc, 32'hBFC00004);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and the FETCH/EXEC phase toggle.
- Consumes the registered `jump_addr_selection` from branch control. Applies the jump or branch target at the end of the branch-delay-slot instruction's EXEC.
- Supplies the fetch address to the instruction bus, `state` to control logic, and the link value (PC+8) to the register-file write mux.
- Stops the CPU (`active` low) when control transfers to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, jump target that ends execution.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- stall  input  1  high while the current EXEC must be repeated (multi-cycle load)
- instruction_word  input  32  instruction currently in EXEC
- rs_data  input  32  register rs read value for the instruction in EXEC
- jump_addr_selection  input  2  registered by branch control at end of EXEC: 00 none, 01 register, 10 page absolute, 11 PC-relative
- pc  output  32  address of the instruction being fetched/executed
- state  output  1  0 = FETCH, 1 = EXEC
- link_addr  output  32  pc + 8, combinational
- active  output  1  high until halt

Behaviour:
- Reset (async, reset_n low), all registers:
  - pc = RESET_VECTOR
  - state = 0
  - active = 1
  - slot_pending = 0
  - reg_tgt, page_tgt and rel_tgt = 0
- Reset mid-operation discards any pending target.
- FSM (state register) has three states:
  - FETCH: next cycle always goes to EXEC.
  - EXEC with stall = 1: stays in EXEC. pc, targets and slot_pending hold.
  - EXEC with stall = 0: goes to FETCH and performs the update step below.
  - HALT (active = 0): state = 0, all registers frozen until reset.
- Target capture at every non-stalled EXEC, from the current instruction:
  - reg_tgt <= rs_data
  - page_tgt <= {pc_plus4[31:28], instruction_word[25:0], 2'b00}
  - rel_tgt <= pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}), where imm = instruction_word[15:0]
  - All arithmetic is modulo 2^32; wrap-around is silent.
  - slot_pending <= 1, set after the first completed EXEC following reset.
- PC update, also at every non-stalled EXEC, using the captured targets from the previous EXEC (the branch instruction):
  - If slot_pending = 1 and jump_addr_selection != 00, pc <= the selected target (01 reg_tgt, 10 page_tgt, 11 rel_tgt).
  - Otherwise pc <= pc + 4.
  - jump_addr_selection is ignored while slot_pending = 0, because branch control has no reset.
- Capture and update happen in the same edge. The update reads the old target registers, so a branch in the delay slot of another branch does not overwrite the active target.
- Latency: a branch at address A executes the instruction at A+4 (delay slot) next. The FETCH following the delay slot's EXEC presents the target.
- Halt: if the PC update would load HALT_ADDR from a taken selection, then:
  - pc <= HALT_ADDR
  - active <= 0 on the same edge
  - the FSM enters HALT
- Sequential fall-through to 0 (pc + 4 wrapping) does not halt.
- Target addresses with bits [1:0] != 0 (reg_tgt only) are passed unchanged; alignment checking happens elsewhere.
- pc updates only on the EXEC→FETCH edge; it is stable throughout FETCH and EXEC.

Test Plan:
- Reset → pc = 32'hBFC00000, state = 0, active = 1. Over 6 cycles with no stall and selection 00, pc steps BFC00000, BFC00004, BFC00008, changing every second edge.
- BEQ at BFC00000 with imm = 16'h0003, selection 11 presented after its EXEC → delay slot BFC00004 executes, then pc = BFC00010.
- Negative offset: imm = 16'hFFFE at BFC00008, selection 11 → after delay slot, pc = BFC00004. Page jump J with index 26'h0000100 from BFC00000 → pc = B0000400 after the slot.
- JR with rs_data = 0 at BFC0000C, selection 01 → delay slot BFC00010 executes, then pc = 0 and active = 0. Further clocks with stall toggling leave pc = 0 and state = 0.
- Stall held 3 cycles in the delay-slot EXEC → state stays 1 and pc holds. The target is still applied on the first non-stalled EXEC edge.
- Selection = 11 presented immediately after reset (slot_pending = 0) → ignored, pc = BFC00004. Asserting reset_n low mid-EXEC with a pending jump → pc = BFC00000 asynchronously and the pending target is discarded.
